// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// Slot tags carry a fixed-width dest field; narrower register indices are zero-extended.
package fwd_pkg;

  localparam int unsigned FWD_REG_W_MAX = 8;
  localparam int unsigned FWD_SEL_RF    = 0;

  typedef struct packed {
    logic                     valid;
    logic [FWD_REG_W_MAX-1:0] dest;
    logic                     wb_en;
    logic                     mem_read;
  } fwd_slot_t;

  function automatic int unsigned fwd_sel_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic fwd_produces(input fwd_slot_t s,
                                        input logic [FWD_REG_W_MAX-1:0] r);
    return s.valid && s.wb_en && (s.dest == r);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Destination-tag shift register covering EXE (slot 0) through WB (slot DEPTH-1).
// Holds on freeze; slot 0 takes a bubble instead of the issued tag when requested.
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze_i,
  input  logic                  bubble_i,
  input  fwd_slot_t             slot_i,
  output fwd_slot_t [DEPTH-1:0] slots_o
);

  fwd_slot_t [DEPTH-1:0] slots_q, slots_d;

  always_comb begin
    slots_d    = slots_q;
    slots_d[0] = bubble_i ? '0 : slot_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      slots_d[k] = slots_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
    end else if (!freeze_i) begin
      slots_q <= slots_d;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding selectors for EXE sources, load-use / no-forward stall for ID,
// and a saturating stall counter. REG_W must not exceed FWD_REG_W_MAX.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int unsigned REG_W     = 4,
  parameter  int unsigned NUM_SRC   = 3,
  parameter  int unsigned DEPTH     = 3,
  parameter  int unsigned LOAD_SLOT = 2,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned SEL_W     = fwd_sel_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     enable_forward,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_read,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_valid,
  output logic                     hazard_stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]         stall_count
);

  fwd_slot_t [DEPTH-1:0]     slots;
  fwd_slot_t                 issue;
  logic [NUM_SRC*REG_W-1:0]  src_q, src_d;
  logic [NUM_SRC-1:0]        src_valid_q, src_valid_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      bubble;

  always_comb begin
    issue          = '0;
    issue.valid    = 1'b1;
    issue.dest     = FWD_REG_W_MAX'(id_dest);
    issue.wb_en    = id_wb_en;
    issue.mem_read = id_mem_read;
  end

  assign bubble = hazard_stall | flush;

  fwd_tag_pipe #(.DEPTH(DEPTH)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .freeze_i (freeze),
    .bubble_i (bubble),
    .slot_i   (issue),
    .slots_o  (slots)
  );

  // With forwarding, only loads too young to forward stall; without it, any
  // producer that has not yet reached WB stalls.
  always_comb begin
    hazard_stall = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (id_src_valid[i] &&
            fwd_produces(slots[j], FWD_REG_W_MAX'(id_src[i*REG_W +: REG_W]))) begin
          if (enable_forward && (j + 1 < LOAD_SLOT) && slots[j].mem_read) begin
            hazard_stall = 1'b1;
          end
          if (!enable_forward && (j + 2 <= DEPTH)) begin
            hazard_stall = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    logic found;
    fwd_sel = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
      found = 1'b0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (!found && enable_forward && src_valid_q[i] &&
            fwd_produces(slots[k], FWD_REG_W_MAX'(src_q[i*REG_W +: REG_W])) &&
            !(slots[k].mem_read && (k < LOAD_SLOT))) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    src_d       = src_q;
    src_valid_d = src_valid_q;
    cnt_d       = cnt_q;
    if (!freeze) begin
      if (bubble) begin
        src_d       = '0;
        src_valid_d = '0;
      end else begin
        src_d       = id_src;
        src_valid_d = id_src_valid;
      end
      if (hazard_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q       <= '0;
      src_valid_q <= '0;
      cnt_q       <= '0;
    end else begin
      src_q       <= src_d;
      src_valid_q <= src_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: table-driven cycle vectors through an
// expectation queue, plus hand-written reset, flush and saturation sequences.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int unsigned REG_W     = 4;
  localparam int unsigned NUM_SRC   = 3;
  localparam int unsigned DEPTH     = 3;
  localparam int unsigned LOAD_SLOT = 2;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned SEL_W     = 2;
  localparam int          NV        = 34;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     freeze, flush, enable_forward;
  logic [REG_W-1:0]         id_dest;
  logic                     id_wb_en, id_mem_read;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_valid;
  logic                     hazard_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [CNT_W-1:0]         stall_count;

  int checks   = 0;
  int failures = 0;

  fwd_scoreboard #(
    .REG_W     (REG_W),
    .NUM_SRC   (NUM_SRC),
    .DEPTH     (DEPTH),
    .LOAD_SLOT (LOAD_SLOT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .flush          (flush),
    .enable_forward (enable_forward),
    .id_dest        (id_dest),
    .id_wb_en       (id_wb_en),
    .id_mem_read    (id_mem_read),
    .id_src         (id_src),
    .id_src_valid   (id_src_valid),
    .hazard_stall   (hazard_stall),
    .fwd_sel        (fwd_sel),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        en;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic [11:0] src;
    logic [2:0]  sv;
    logic        st;
    logic [5:0]  fwd;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic       st;
    logic [5:0] fwd;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs [NV];
  exp_t exp_q [$];

  function automatic vec_t v(input logic frz, input logic en, input logic [3:0] dest,
                             input logic wb, input logic mr, input logic [11:0] src,
                             input logic [2:0] sv, input logic st, input logic [5:0] fwd,
                             input logic [7:0] cnt);
    vec_t r;
    r.frz = frz; r.en = en; r.dest = dest; r.wb = wb; r.mr = mr;
    r.src = src; r.sv = sv; r.st = st; r.fwd = fwd; r.cnt = cnt;
    return r;
  endfunction

  function automatic vec_t nop(input logic frz, input logic en, input logic st,
                               input logic [5:0] fwd, input logic [7:0] cnt);
    return v(frz, en, 4'd0, 1'b0, 1'b0, 12'h000, 3'b000, st, fwd, cnt);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic frz, input logic fl, input logic en, input logic [3:0] dest,
                       input logic wb, input logic mr, input logic [11:0] src,
                       input logic [2:0] sv);
    freeze = frz; flush = fl; enable_forward = en; id_dest = dest;
    id_wb_en = wb; id_mem_read = mr; id_src = src; id_src_valid = sv;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    // ALU dependence
    vecs[0]  = v(0, 1, 4'd1, 1, 0, 12'h000, 3'b000, 0, 6'b000000, 8'd0);
    vecs[1]  = v(0, 1, 4'd2, 1, 0, 12'h031, 3'b011, 0, 6'b000000, 8'd0);
    vecs[2]  = nop(0, 1, 0, 6'b000001, 8'd0);
    vecs[3]  = nop(0, 1, 0, 6'b000000, 8'd0);
    vecs[4]  = nop(0, 1, 0, 6'b000000, 8'd0);
    // load-use
    vecs[5]  = v(0, 1, 4'd4, 1, 1, 12'h000, 3'b000, 0, 6'b000000, 8'd0);
    vecs[6]  = v(0, 1, 4'd6, 1, 0, 12'h004, 3'b001, 1, 6'b000000, 8'd0);
    vecs[7]  = v(0, 1, 4'd6, 1, 0, 12'h004, 3'b001, 0, 6'b000000, 8'd1);
    vecs[8]  = nop(0, 1, 0, 6'b000010, 8'd1);
    vecs[9]  = nop(0, 1, 0, 6'b000000, 8'd1);
    vecs[10] = nop(0, 1, 0, 6'b000000, 8'd1);
    // forwarding off
    vecs[11] = v(0, 0, 4'd7, 1, 0, 12'h000, 3'b000, 0, 6'b000000, 8'd1);
    vecs[12] = v(0, 0, 4'd8, 1, 0, 12'h007, 3'b001, 1, 6'b000000, 8'd1);
    vecs[13] = v(0, 0, 4'd8, 1, 0, 12'h007, 3'b001, 1, 6'b000000, 8'd2);
    vecs[14] = v(0, 0, 4'd8, 1, 0, 12'h007, 3'b001, 0, 6'b000000, 8'd3);
    vecs[15] = nop(0, 0, 0, 6'b000000, 8'd3);
    vecs[16] = nop(0, 1, 0, 6'b000000, 8'd3);
    vecs[17] = nop(0, 1, 0, 6'b000000, 8'd3);
    // double producer of r5; src1 invalid, src2 (store data) valid
    vecs[18] = v(0, 1, 4'd5, 1, 0, 12'h000, 3'b000, 0, 6'b000000, 8'd3);
    vecs[19] = v(0, 1, 4'd5, 1, 0, 12'h000, 3'b000, 0, 6'b000000, 8'd3);
    vecs[20] = v(0, 1, 4'd9, 1, 0, 12'h555, 3'b101, 0, 6'b000000, 8'd3);
    vecs[21] = nop(1, 0, 0, 6'b000000, 8'd3);
    vecs[22] = nop(0, 1, 0, 6'b010001, 8'd3);
    vecs[23] = nop(0, 1, 0, 6'b000000, 8'd3);
    vecs[24] = nop(0, 1, 0, 6'b000000, 8'd3);
    // freeze during load-use
    vecs[25] = v(0, 1, 4'd4, 1, 1, 12'h000, 3'b000, 0, 6'b000000, 8'd3);
    vecs[26] = v(1, 1, 4'd6, 1, 0, 12'h004, 3'b001, 1, 6'b000000, 8'd3);
    vecs[27] = v(1, 1, 4'd6, 1, 0, 12'h004, 3'b001, 1, 6'b000000, 8'd3);
    vecs[28] = v(1, 1, 4'd6, 1, 0, 12'h004, 3'b001, 1, 6'b000000, 8'd3);
    vecs[29] = v(0, 1, 4'd6, 1, 0, 12'h004, 3'b001, 1, 6'b000000, 8'd3);
    vecs[30] = v(0, 1, 4'd6, 1, 0, 12'h004, 3'b001, 0, 6'b000000, 8'd4);
    vecs[31] = nop(0, 1, 0, 6'b000010, 8'd4);
    vecs[32] = nop(0, 1, 0, 6'b000000, 8'd4);
    vecs[33] = nop(0, 1, 0, 6'b000000, 8'd4);

    rst = 1'b1;
    drive(0, 0, 1, 4'd0, 0, 0, 12'h000, 3'b000);
    #2;
    check("reset_stall", 0, 32'(hazard_stall), 32'd0);
    check("reset_fwd",   0, 32'(fwd_sel),      32'd0);
    check("reset_cnt",   0, 32'(stall_count),  32'd0);
    next(); next();
    rst = 1'b0;

    for (int n = 0; n < NV; n++) begin
      drive(vecs[n].frz, 1'b0, vecs[n].en, vecs[n].dest, vecs[n].wb, vecs[n].mr,
            vecs[n].src, vecs[n].sv);
      exp_q.push_back('{idx: n, st: vecs[n].st, fwd: vecs[n].fwd, cnt: vecs[n].cnt});
      #2;
      if (exp_q.size() == 0) begin
        check("queue_empty", n, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("vec_stall", e.idx, 32'(hazard_stall), 32'(e.st));
        check("vec_fwd",   e.idx, 32'(fwd_sel),      32'(e.fwd));
        check("vec_cnt",   e.idx, 32'(stall_count),  32'(e.cnt));
      end
      next();
    end

    // saturation: repeated self-dependent writes of r1 with forwarding off
    drive(0, 0, 0, 4'd1, 1, 0, 12'h001, 3'b001);
    for (int n = 0; n < 450; n++) next();
    drive(0, 0, 1, 4'd0, 0, 0, 12'h000, 3'b000);
    next(); next(); next();
    #1;
    check("sat_cnt", 0, 32'(stall_count), 32'hFF);
    next();
    check("sat_hold", 0, 32'(stall_count), 32'hFF);

    // reset during a load-use stall
    drive(0, 0, 1, 4'd4, 1, 1, 12'h000, 3'b000);
    next();
    drive(0, 0, 1, 4'd6, 1, 0, 12'h004, 3'b001);
    #2;
    check("pre_rst_stall", 0, 32'(hazard_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_stall", 0, 32'(hazard_stall), 32'd0);
    check("rst_cnt",   0, 32'(stall_count),  32'd0);
    check("rst_fwd",   0, 32'(fwd_sel),      32'd0);
    next();
    rst = 1'b0;
    #2;
    check("post_rst_stall", 0, 32'(hazard_stall), 32'd0);
    next();

    // flush inserts a bubble in place of the r3 producer
    drive(0, 1, 0, 4'd3, 1, 0, 12'h000, 3'b000);
    #2;
    check("flush_stall", 0, 32'(hazard_stall), 32'd0);
    next();
    drive(0, 0, 0, 4'd0, 0, 0, 12'h003, 3'b001);
    #2;
    check("after_flush_stall", 0, 32'(hazard_stall), 32'd0);
    next();

    // flush together with a load-use stall
    drive(0, 0, 1, 4'd4, 1, 1, 12'h000, 3'b000);
    next();
    drive(0, 1, 1, 4'd6, 1, 0, 12'h004, 3'b001);
    #2;
    check("flush_ldu_stall", 0, 32'(hazard_stall), 32'd1);
    check("flush_ldu_cnt0",  0, 32'(stall_count),  32'd0);
    next();
    drive(0, 0, 1, 4'd6, 1, 0, 12'h004, 3'b001);
    #2;
    check("flush_ldu_after", 0, 32'(hazard_stall), 32'd0);
    check("flush_ldu_cnt1",  0, 32'(stall_count),  32'd1);
    next();
    drive(0, 0, 1, 4'd0, 0, 0, 12'h000, 3'b000);
    #2;
    check("flush_ldu_fwd", 0, 32'(fwd_sel), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the ARM-style pipeline. It holds its own destination-tag pipeline covering EXE through WB, so the execute stage does not have to supply per-stage destination buses. Each cycle it produces one forwarding selector per EXE-stage source operand, plus a load-use or no-forward stall for the instruction in ID. It also keeps a saturating stall counter for performance reporting. It sits beside the ID/EXE register and is frozen by the same memory-wait signal as the pipeline.

## Interface
- REG_W, 4: register index width.
- NUM_SRC, 3: source operands per instruction; the third is the store-data register.
- DEPTH, 3: number of tracked slots. Slot 0 is EXE, slot DEPTH-1 is WB. Must be ≥2.
- LOAD_SLOT, 2: lowest slot whose load data is forwardable.
- CNT_W, 16: stall counter width.

Ports (clock and reset first):
- clk  in  1  pipeline clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  memory wait; holds all state.
- flush  in  1  branch taken; the ID instruction enters EXE as a bubble.
- enable_forward  in  1  0 disables forwarding; all hazards then stall.
- id_dest  in  REG_W  destination register of the ID instruction.
- id_wb_en  in  1  ID instruction writes a register.
- id_mem_read  in  1  ID instruction is a load.
- id_src  in  NUM_SRC*REG_W  ID source indices; source i is at bits [i*REG_W +: REG_W].
- id_src_valid  in  NUM_SRC  per-source use flags.
- hazard_stall  out  1  hold PC and IF/ID; insert a bubble into EXE.
- fwd_sel  out  NUM_SRC*SEL_W  per EXE source. 0 selects the register file; k selects the result from slot k (1..DEPTH-1). SEL_W = $clog2(DEPTH).
- stall_count  out  CNT_W  cycles in which hazard_stall was asserted and freeze was low; saturates.

## Operation
- Each slot holds {valid, dest, wb_en, mem_read}. A slot "produces r" when valid & wb_en & dest==r.
- EXE source registers hold the ID src and src_valid values latched on advance.
- **Stall (combinational, from ID values).** hazard_stall=1 when some source i has id_src_valid[i]=1 and either:
  - enable_forward=1, slot j (j+1<LOAD_SLOT) produces src[i], and that slot's mem_read=1; or
  - enable_forward=0 and slot j (0≤j≤DEPTH-2) produces src[i].
- **Forward (combinational, from EXE values).** For each valid EXE source, fwd_sel = the lowest k in 1..DEPTH-1 whose slot produces that source.
  - A slot k holding a load with k<LOAD_SLOT is skipped.
  - When enable_forward=0, or the source is invalid, or there is no match, fwd_sel=0.
  - The youngest producer wins.
- **Advance** on posedge when freeze=0:
  - slots shift: slot k ← slot k-1;
  - slot 0 ← bubble (valid=0) if hazard_stall or flush, otherwise {1, id_dest, id_wb_en, id_mem_read};
  - EXE source registers load the ID values, or are cleared (src_valid=0) on a bubble.
- **Freeze** holds all slots, the EXE source registers and stall_count. hazard_stall and fwd_sel still evaluate combinationally on the held state.
- **Counter.** stall_count increments when hazard_stall=1 and freeze=0, and saturates at all-ones.
- **Flush with stall.** The bubble is inserted; hazard_stall still reports the ID hazard.

## Timing
- Reset (async, immediate): all slots valid=0, EXE source registers cleared, stall_count=0. Outputs follow at once: hazard_stall=0, fwd_sel=0.
- Reset mid-operation discards all in-flight tags. The first post-reset cycle behaves as an empty pipeline.
- hazard_stall and fwd_sel are zero-latency combinational outputs of the current state and inputs.
- A tag issued at edge n is in slot k from edge n+k until edge n+k+1, absent freeze. Each frozen cycle adds one cycle.
- Load-use with defaults costs exactly one stall cycle. Without forwarding, a dependent instruction stalls DEPTH-1 cycles.

## Structure
- Package fwd_pkg holds:
  - the slot typedef struct {valid, dest, wb_en, mem_read};
  - the FWD_SEL_RF=0 constant;
  - a function giving SEL_W from DEPTH.
- Sub-module fwd_tag_pipe: the DEPTH-slot shift register, with freeze, bubble insert and async reset. The top level holds the compare logic, the EXE source registers and the counter.

## Test plan
- **ALU dependence.** Issue r1←… then r2←r1+r3 (src0=1). On the second instruction's EXE cycle, fwd_sel[src0]=1, hazard_stall stays 0, stall_count stays 0.
- **Load-use.** Issue LDR r4, then ADD using r4. Expect hazard_stall=1 for one cycle, then fwd_sel[src0]=2, and stall_count=1.
- **Forwarding off.** With enable_forward=0 and the same dependent pair, expect hazard_stall for 2 cycles, fwd_sel=0 throughout, and stall_count=2.
- **Double producer.** Slots 1 and 2 both write r5 → fwd_sel=1. With id_src_valid[1]=0, r5 on src1 → fwd_sel[src1]=0.
- **Freeze.** Hold freeze=1 for 3 cycles during a load-use stall. Slots, stall_count and outputs stay unchanged. After release, the sequence completes as in the load-use case.
- **Reset and saturation.** Assert rst mid-stall → immediate hazard_stall=0 and stall_count=0. Forcing 2^CNT_W+5 stall cycles → stall_count=all-ones.
